// File: rtl/hpi_axil_arb.sv
// Round-robin arbiter sharing one HPI-to-AXI4-Lite adapter; request->cmd 1 clk, vld->done 1 clk, one txn outstanding.
// Requests are level-held and wait while busy. HPI_ARB_TMOUT_EN adds a WAIT timeout with error completion.
module hpi_axil_arb #(
    parameter int REQ_NUM       = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_BYTE_NUM = DATA_WIDTH/8,
    parameter int TMOUT_CYC     = 1024
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic [REQ_NUM-1:0]                 req_wr,
    input  logic [REQ_NUM-1:0]                 req_rd,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0]      req_addr,
    input  logic [REQ_NUM*DATA_BYTE_NUM-1:0]   req_strb,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]      req_wdata,
    output logic [REQ_NUM-1:0]                 req_ack,
    output logic [REQ_NUM-1:0]                 req_done,
    output logic                               req_err,
    output logic [DATA_WIDTH-1:0]              req_rdata,
    output logic                               cpu_wr,
    output logic                               cpu_rd,
    output logic [ADDR_WIDTH-1:0]              cpu_wr_addr,
    output logic [ADDR_WIDTH-1:0]              cpu_rd_addr,
    output logic [DATA_BYTE_NUM-1:0]           cpu_wr_strb,
    output logic [DATA_WIDTH-1:0]              cpu_data_in,
    input  logic                               cpu_data_out_vld,
    input  logic [DATA_WIDTH-1:0]              cpu_data_out,
    output logic                               busy,
    output logic [2:0]                         grant_id,
    output logic [15:0]                        tmout_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]                r_state;
    logic [2:0]                r_grant;
    logic [2:0]                r_rr_ptr;
    logic                      r_op_wr;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_BYTE_NUM-1:0]  r_strb;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH-1:0]     r_rdata;

    logic [REQ_NUM-1:0]        w_pend;
    logic [2*REQ_NUM-1:0]      w_pend2;
    logic [2*REQ_NUM-1:0]      w_shift;
    logic [REQ_NUM-1:0]        w_rot;
    logic [3:0]                w_sum;
    logic [2:0]                w_sel;
    logic                      w_found;
    logic [REQ_NUM-1:0]        w_sel_oh;
    logic [REQ_NUM-1:0]        w_gnt_oh;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [DATA_BYTE_NUM-1:0]  w_strb;
    logic [DATA_WIDTH-1:0]     w_wdata;

    assign w_pend  = req_wr | req_rd;
    assign w_pend2 = {w_pend, w_pend};
    assign w_shift = w_pend2 >> r_rr_ptr;

    // Rotate pending so bit 0 is rr_ptr; the lowest set bit of the rotated vector wins.
    always_comb begin
        w_rot   = w_shift[REQ_NUM-1:0];
        w_found = |w_pend;
        w_sum   = '0;
        w_sel   = '0;
        for (int k = REQ_NUM-1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, r_rr_ptr} + 4'(k);
                w_sel = (w_sum >= 4'(REQ_NUM)) ? 3'(w_sum - 4'(REQ_NUM)) : w_sum[2:0];
            end
        end
    end

    always_comb begin
        w_sel_oh = '0;
        w_gnt_oh = '0;
        w_addr   = '0;
        w_strb   = '0;
        w_wdata  = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            w_sel_oh[i] = (w_sel == 3'(i));
            w_gnt_oh[i] = (r_grant == 3'(i));
            if (w_sel_oh[i]) begin
                w_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_strb  = req_strb[i*DATA_BYTE_NUM +: DATA_BYTE_NUM];
                w_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef HPI_ARB_TMOUT_EN
    logic [15:0] r_wait_cnt;
    logic [15:0] r_tmout_cnt;
    logic        r_err;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_op_wr  <= 1'b0;
            r_addr   <= '0;
            r_strb   <= '1;
            r_wdata  <= '0;
            r_rdata  <= '0;
`ifdef HPI_ARB_TMOUT_EN
            r_wait_cnt  <= '0;
            r_tmout_cnt <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel;
                        // A requester holding both gets its write served first.
                        r_op_wr <= |(req_wr & w_sel_oh);
                        r_addr  <= w_addr;
                        r_strb  <= w_strb;
                        r_wdata <= w_wdata;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_rr_ptr <= (r_grant == 3'(REQ_NUM-1)) ? 3'd0 : r_grant + 3'd1;
                    r_state  <= S_WAIT;
`ifdef HPI_ARB_TMOUT_EN
                    r_wait_cnt <= '0;
                    r_err      <= 1'b0;
`endif
                end
                S_WAIT: begin
                    if (cpu_data_out_vld) begin
                        r_rdata <= r_op_wr ? '0 : cpu_data_out;
                        r_state <= S_RESP;
                    end
`ifdef HPI_ARB_TMOUT_EN
                    else if (r_wait_cnt == 16'(TMOUT_CYC-1)) begin
                        r_err   <= 1'b1;
                        r_rdata <= '1;
                        r_state <= S_RESP;
                        if (r_tmout_cnt != 16'hFFFF) r_tmout_cnt <= r_tmout_cnt + 16'd1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ack     = (r_state == S_ISSUE) ? w_gnt_oh : '0;
    assign req_done    = (r_state == S_RESP)  ? w_gnt_oh : '0;
    assign cpu_wr      = (r_state == S_ISSUE) &&  r_op_wr;
    assign cpu_rd      = (r_state == S_ISSUE) && !r_op_wr;
    assign cpu_wr_addr = r_addr;
    assign cpu_rd_addr = r_addr;
    assign cpu_wr_strb = r_strb;
    assign cpu_data_in = r_wdata;
    assign req_rdata   = r_rdata;
    assign busy        = (r_state != S_IDLE);
    assign grant_id    = r_grant;

`ifdef HPI_ARB_TMOUT_EN
    assign req_err   = (r_state == S_RESP) && r_err;
    assign tmout_cnt = r_tmout_cnt;
`else
    logic [31:0] w_unused_tmout;
    assign w_unused_tmout = 32'(TMOUT_CYC);
    assign req_err   = 1'b0;
    assign tmout_cnt = 16'd0;
`endif

endmodule

// File: doc/hpi_axil_arb.md
# hpi_axil_arb

Round-robin arbiter and transaction sequencer sharing one HPI-to-AXI4-Lite master adapter among `REQ_NUM` register-access requesters. It accepts level-held read/write requests and issues one single-cycle `cpu_wr`/`cpu_rd` pulse downstream. It waits for the adapter's `cpu_data_out_vld`, then returns completion and read data to the granted requester. Only one transaction is ever outstanding on the adapter.

## Interface
Parameters:
- `REQ_NUM`, 4: number of requesters, 2..8
- `ADDR_WIDTH`, 32: address width
- `DATA_WIDTH`, 32: data width
- `DATA_BYTE_NUM`, `DATA_WIDTH/8`: strobe width
- `TMOUT_CYC`, 1024: response timeout in clocks; used only with `HPI_ARB_TMOUT_EN`

Ports:
- `aclk`  in  1  clock; one clock domain
- `areset`  in  1  reset; synchronous, active-high
- `req_wr`  in  REQ_NUM  per-requester write request; held until `req_ack`
- `req_rd`  in  REQ_NUM  per-requester read request; held until `req_ack`
- `req_addr`  in  REQ_NUM*ADDR_WIDTH  packed address; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_strb`  in  REQ_NUM*DATA_BYTE_NUM  packed write strobes
- `req_wdata`  in  REQ_NUM*DATA_WIDTH  packed write data
- `req_ack`  out  REQ_NUM  one-hot, 1-cycle pulse: request accepted
- `req_done`  out  REQ_NUM  one-hot, 1-cycle pulse: transaction complete
- `req_err`  out  1  qualifies `req_done`: timeout completion
- `req_rdata`  out  DATA_WIDTH  read data; valid with `req_done`
- `cpu_wr`, `cpu_rd`  out  1 each  downstream command pulses
- `cpu_wr_addr`, `cpu_rd_addr`  out  ADDR_WIDTH  downstream addresses
- `cpu_wr_strb`  out  DATA_BYTE_NUM  downstream write strobe
- `cpu_data_in`  out  DATA_WIDTH  downstream write data
- `cpu_data_out_vld`  in  1  downstream completion (write response or read data)
- `cpu_data_out`  in  DATA_WIDTH  downstream read data
- `busy`  out  1  state != IDLE
- `grant_id`  out  3  index of the current or last granted requester
- `tmout_cnt`  out  16  saturating timeout count

## Operation
- **FSM:** IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE:**
  - A requester is pending if `req_wr[i] | req_rd[i]`.
  - Pick the first pending index searching from `rr_ptr` upward, modulo `REQ_NUM`.
  - Register grant, op, addr, strb and wdata; go to ISSUE.
- **ISSUE (1 cycle):**
  - Assert exactly one of `cpu_wr`/`cpu_rd` for the granted requester.
  - Drive both address ports with the granted address.
  - Assert `req_ack[grant]`.
  - Set `rr_ptr = (grant+1) mod REQ_NUM`.
  - Go to WAIT.
- **Write priority:** if a requester holds both `req_wr` and `req_rd`, the write is served and acked. The read stays pending and competes again.
- **WAIT:**
  - The first cycle with `cpu_data_out_vld=1` captures `cpu_data_out` into the response register.
  - Go to RESP.
- **RESP (1 cycle):**
  - `req_done[grant]=1`.
  - `req_rdata` = captured data for reads, 0 for writes.
  - Go to IDLE.
- **Stray completions:** `cpu_data_out_vld` outside WAIT is ignored.
- **Requester contract:** a requester must drop its request the cycle after `req_ack`. A re-assertion is treated as a new request.
- **Data outputs:** `cpu_wr_addr`/`cpu_rd_addr`/`cpu_wr_strb`/`cpu_data_in` hold their last value outside ISSUE.

## Timing
- **Reset values:**
  - All pulses (`cpu_wr`, `cpu_rd`, `req_ack`, `req_done`, `req_err`) = 0.
  - All addresses and data outputs = 0; `cpu_wr_strb` = all ones.
  - `busy=0`, `grant_id=0`, `rr_ptr=0`, `tmout_cnt=0`.
- **Request to command:** request seen in IDLE at cycle T → `cpu_wr`/`cpu_rd` and `req_ack` at T+1.
- **Completion:** `cpu_data_out_vld` at cycle V (in WAIT) → `req_done` at V+1.
- **Back-to-back:** next grant evaluated at V+2 (IDLE), so the next ISSUE is at V+3 at the earliest.
- **Request in flight:** requests arriving while busy wait; no loss, no queue beyond held levels.
- **Reset mid-operation:** `areset` in any state → IDLE on the next edge, all outputs at reset values. No `req_done` is emitted for the aborted transaction. A late `cpu_data_out_vld` is ignored.

## Configuration
- **`HPI_ARB_TMOUT_EN` defined:**
  - 16-bit WAIT counter cleared on ISSUE.
  - If the counter reaches `TMOUT_CYC-1` without `cpu_data_out_vld`, go to RESP with `req_err=1` and `req_rdata={DATA_WIDTH{1'b1}}`.
  - `tmout_cnt` increments, saturating at 16'hFFFF.
  - A vld in the same cycle as expiry wins: normal completion, `req_err=0`.
- **`HPI_ARB_TMOUT_EN` undefined:**
  - WAIT persists until `cpu_data_out_vld`.
  - `req_err` and `tmout_cnt` are tied to 0; no counter logic.

## Test plan
- Single write from requester 2 (addr 0x0000_0010, data 0xA5A5_5A5A, strb 0xF); response model returns vld 4 cycles after `cpu_wr` → `req_ack[2]` 1 cycle after request, `req_done[2]` 1 cycle after vld, `req_rdata=0`, `req_err=0`.
- Read from requester 0; model returns 0x1234_5678 → `req_done[0]` with `req_rdata=0x1234_5678`; `cpu_rd` asserted for exactly 1 cycle.
- All 4 requesters assert reads simultaneously after reset → grant order 0,1,2,3. Then requesters 3 and 1 both re-request → order 1,3 with `rr_ptr=0`.
- Requester 1 holds `req_wr` and `req_rd` together → write issued first, then read in a later grant; one `req_ack` per transaction.
- With `HPI_ARB_TMOUT_EN` and `TMOUT_CYC=16`, the model never responds → `req_done` with `req_err=1`, `req_rdata=0xFFFF_FFFF`, `tmout_cnt=1`. A vld injected afterwards is ignored.
- `areset` pulsed during WAIT, then vld arrives → no `req_done`, `busy=0`, next request granted from `rr_ptr=0`.
